// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - exhaustive truth-table sweep and check of a combinational block
// Drives every input vector in ascending order, samples the output after a settle delay,
// and compares the captured table against an expected table latched at start.
module truth_table_sequencer #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   y_in,
  output logic [N_IN-1:0]        x_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        first_fail,
  output logic                   fail_valid,
  output logic                   pass
);

  localparam int NVEC = 1 << N_IN;
  localparam int CW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN+1)'(NVEC);
  localparam logic [N_IN-1:0] X_LAST   = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic [NVEC-1:0]   exp_q, exp_d;
  logic [NVEC-1:0]   table_q, table_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              fv_q, fv_d;
  logic              pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    exp_d   = exp_q;
    table_d = table_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fv_d    = fv_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          exp_d   = expected;
          table_d = '0;
          err_d   = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          x_d     = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          x_d     = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_SAMPLE: begin
        // An aborted sample leaves the partial results untouched.
        if (abort) begin
          state_d = ST_IDLE;
          x_d     = '0;
        end else begin
          table_d[x_q] = y_in;
          if (y_in != exp_q[x_q]) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + (N_IN+1)'(1);
            end
            if (!fv_q) begin
              ff_d = x_q;
              fv_d = 1'b1;
            end
          end
          if (x_q == X_LAST) begin
            state_d = ST_DONE;
          end else begin
            x_d     = x_q + N_IN'(1);
            cnt_d   = CNT_LOAD;
            state_d = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        x_d     = '0;
        if (!abort) begin
          pass_d = (err_q == '0);
        end
      end

      default: begin
        state_d = ST_IDLE;
        x_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      exp_q   <= '0;
      table_q <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      pass_q  <= pass_d;
    end
  end

  assign x_out      = x_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign table_out  = table_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;
  assign pass       = pass_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - scoreboard bench for truth_table_sequencer
module tb_truth_table_sequencer;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  err;
    logic [3:0]  ff;
    logic        fv;
    logic        pss;
    int          dcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [15:0] expected;
  logic        y_mode;
  logic        y_in;
  logic [3:0]  x_out;
  logic        busy, done, fail_valid, pass;
  logic [15:0] table_out;
  logic [4:0]  err_count;
  logic [3:0]  first_fail;

  logic        start2;
  logic [15:0] expected2;
  logic        y2;
  logic [3:0]  x2;
  logic        busy2, done2, fail_valid2, pass2;
  logic [15:0] table2;
  logic [4:0]  err2;
  logic [3:0]  ff2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  exp_t q[$];
  exp_t q2[$];
  exp_t cur;
  logic pass_pend = 1'b0;
  logic pass_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign y_in = y_mode ? ^x_out : 1'b0;
  assign y2   = ^x2;

  truth_table_sequencer #(.N_IN(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .y_in(y_in), .x_out(x_out), .busy(busy), .done(done), .table_out(table_out),
    .err_count(err_count), .first_fail(first_fail), .fail_valid(fail_valid), .pass(pass)
  );

  truth_table_sequencer #(.N_IN(4), .SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .expected(expected2),
    .y_in(y2), .x_out(x2), .busy(busy2), .done(done2), .table_out(table2),
    .err_count(err2), .first_fail(ff2), .fail_valid(fail_valid2), .pass(pass2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the main DUT: pops one expectation per done pulse; pass is checked a cycle later.
  always @(negedge clk) begin
    if (pass_pend) begin
      chk("pass", pass, pass_exp);
      pass_pend = 1'b0;
    end
    if (rst_n && done) begin
      done_count++;
      if (q.size() == 0) begin
        chk("unexpected_done", done, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_cycle", cyc, e.dcyc);
        chk("table_out", table_out, e.tbl);
        chk("err_count", err_count, e.err);
        chk("first_fail", first_fail, e.ff);
        chk("fail_valid", fail_valid, e.fv);
        pass_exp  = e.pss;
        pass_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", done2, 1'b0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("done2_cycle", cyc, e.dcyc);
        chk("table2", table2, e.tbl);
        chk("err2", err2, e.err);
        chk("fail_valid2", fail_valid2, e.fv);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || q2.size() != 0 || pass_pend) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("drain_timeout", q.size() + q2.size(), 0);
      q.delete();
      q2.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Issues a start on the next edge and queues the expected results; returns the accepting edge.
  task automatic launch(input logic [15:0] exp_tbl, input logic ym, input exp_t e, output int k);
    expected = exp_tbl;
    y_mode   = ym;
    start    = 1'b1;
    k        = cyc + 1;
    cur      = e;
    cur.dcyc = k + 48;
    q.push_back(cur);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int k;
    int dc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = 16'h0000; y_mode = 1'b1;
    start2 = 1'b0; expected2 = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_x_out", x_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_table", table_out, 0);
    chk("rst_err", err_count, 0);
    chk("rst_ff", first_fail, 0);
    chk("rst_fv", fail_valid, 0);
    chk("rst_pass", pass, 0);

    // Clean XOR scan, also checking vector stepping cycle by cycle.
    launch(16'h6996, 1'b1, '{16'h6996, 5'd0, 4'd0, 1'b0, 1'b1, 0}, k);
    for (int t = 0; t < 48; t++) begin
      if (t > 0) @(negedge clk);
      chk("scan_x_out", x_out, t / 3);
      chk("scan_busy", busy, 1);
    end
    wait_drain();
    chk("idle_busy", busy, 0);
    chk("idle_x_out", x_out, 0);

    launch(16'h6997, 1'b1, '{16'h6996, 5'd1, 4'd0, 1'b1, 1'b0, 0}, k);
    wait_drain();
    launch(16'hE996, 1'b1, '{16'h6996, 5'd1, 4'd15, 1'b1, 1'b0, 0}, k);
    wait_drain();
    launch(16'hFFFF, 1'b0, '{16'h0000, 5'd16, 4'd0, 1'b1, 1'b0, 0}, k);
    wait_drain();

    // Abort on edge k+20: six vectors (0..5) sampled, no done.
    dc = done_count;
    expected = 16'h6996; y_mode = 1'b1; start = 1'b1; k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_x_out", x_out, 0);
    chk("abort_table", table_out, 16'h0016);
    chk("abort_err", err_count, 0);
    chk("abort_fv", fail_valid, 0);
    repeat (60) @(negedge clk);
    chk("abort_no_done", done_count, dc);
    chk("abort_pass", pass, 0);
    launch(16'h6996, 1'b1, '{16'h6996, 5'd0, 4'd0, 1'b0, 1'b1, 0}, k);
    wait_drain();

    // Start re-pulsed mid-scan and expected changed: original table still governs.
    dc = done_count;
    launch(16'h6996, 1'b1, '{16'h6996, 5'd0, 4'd0, 1'b0, 1'b1, 0}, k);
    repeat (4) @(negedge clk);
    start = 1'b1; expected = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    repeat (41) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);
    chk("repulse_one_done", done_count, dc + 1);
    chk("repulse_busy", busy, 0);

    // Reset mid-scan clears everything, including the earlier pass.
    expected = 16'h6997; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_x_out", x_out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_table", table_out, 0);
    chk("mrst_err", err_count, 0);
    chk("mrst_ff", first_fail, 0);
    chk("mrst_fv", fail_valid, 0);
    chk("mrst_pass", pass, 0);
    repeat (60) @(negedge clk);

    // SETTLE_CYCLES=1 instance: two cycles per vector, done 32 edges after start.
    expected2 = 16'h6996; start2 = 1'b1;
    cur = '{16'h6996, 5'd0, 4'd0, 1'b0, 1'b1, 0};
    cur.dcyc = cyc + 1 + 32;
    q2.push_back(cur);
    @(negedge clk);
    start2 = 1'b0;
    wait_drain();
    chk("s1_pass", pass2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Self-checking sweep controller for a combinational function block with N_IN inputs and one output. On a start request it drives every input vector 0 to 2^N_IN−1 in ascending order. For each vector it waits a programmable settle time, samples the output, and builds the captured truth table. It compares the capture against an expected table latched at start and reports a pass/fail summary. It replaces open-loop stimulus sequences with a clocked, reusable, hardware-checkable scan of the function block.

## Interface
Parameters:
- N_IN, 4, number of function-block inputs; vector space is 2^N_IN (minimum 1).
- SETTLE_CYCLES, 2, cycles each vector is held before sampling (minimum 1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  scan request, sampled only in IDLE.
- abort  in  1  terminate scan; sampled in every state.
- expected  in  2^N_IN  expected truth table; bit i is the expected output for vector i. Latched on start.
- y_in  in  1  function-block output.
- x_out  out  N_IN  vector driven to the function-block inputs; x_out[N_IN−1] is the MSB (x3 when N_IN=4).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a scan completes normally.
- table_out  out  2^N_IN  captured truth table; bit i is the value sampled for vector i.
- err_count  out  N_IN+1  number of mismatching vectors in the current/last scan.
- first_fail  out  N_IN  index of the lowest mismatching vector.
- fail_valid  out  1  at least one mismatch has been recorded.
- pass  out  1  high after a completed scan with err_count==0; held until the next accepted start.

## Operation
States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: busy=0.
  - start=1 and abort=0:
    - latch expected;
    - clear table_out, err_count, first_fail, fail_valid and pass;
    - set x_out=0 and load the settle counter;
    - go to SETTLE.
  - start=1 and abort=1: stay in IDLE, no state changes.
- SETTLE: x_out is held constant. The counter runs SETTLE_CYCLES cycles, then the state goes to SAMPLE.
- SAMPLE, one cycle, on its closing edge:
  - write table_out[x_out] ← y_in;
  - if y_in ≠ latched expected[x_out]:
    - increment err_count;
    - if fail_valid=0, set first_fail ← x_out and fail_valid ← 1.
  - If x_out = 2^N_IN−1, go to DONE. Otherwise increment x_out, reload the counter and go to SETTLE.
- DONE, one cycle: done=1 and pass ← (err_count==0), including any error from the final sample. Then go to IDLE with x_out ← 0.
- abort=1 in SETTLE, SAMPLE or DONE: next state is IDLE and x_out ← 0.
  - done is not pulsed and pass stays 0.
  - table_out, err_count and the fail fields keep their partial values.
  - A SAMPLE cut short by abort does not write.
- start while busy=1 is ignored. It is not queued.
- Arithmetic:
  - err_count saturates at 2^N_IN, so it cannot overflow N_IN+1 bits.
  - x_out never wraps during a scan; the terminal vector goes to DONE.
- Changes to expected after start has no effect on the running scan.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE; x_out=0, busy=0, done=0, table_out=0, err_count=0, first_fail=0, fail_valid=0, pass=0.
  - Reset takes priority over start and abort.
  - Reset mid-scan discards all results.
- All outputs are registered. There is no combinational path from input to output.
- Let k be the edge that accepts start:
  - busy rises after edge k;
  - vector i is driven from edge k+i·(SETTLE_CYCLES+1) and sampled on edge k+(i+1)·(SETTLE_CYCLES+1);
  - done is high for the cycle after edge k+2^N_IN·(SETTLE_CYCLES+1);
  - busy falls on the following edge, at the same time done falls.
- Defaults (N_IN=4, SETTLE_CYCLES=2): 3 cycles per vector; done appears 48 edges after start acceptance.
- A new start is accepted no earlier than the edge where busy=0, giving back-to-back scans with one idle cycle.
- abort sampled high at edge m: busy=0 and x_out=0 after edge m.

## Test plan
- Bench model y_in = XOR of x_out, expected=16'h6996, start pulse → x_out steps 0..15, each value held 3 cycles. Done pulses once, 48 edges after start. Final results: table_out=16'h6996, err_count=0, fail_valid=0, pass=1.
- Same model, expected=16'h6997 → err_count=1, first_fail=0, fail_valid=1, pass=0 at done. Then expected=16'hE996 → err_count=1, first_fail=15.
- Model y_in=0, expected=16'hFFFF → err_count=16 (no overflow), first_fail=0, table_out=0, pass=0.
- abort asserted 20 edges after start → after that edge busy=0 and x_out=0; done never pulses; table_out holds the six sampled vectors; a subsequent start runs a clean full scan.
- start re-pulsed at edges +5 and +47 during a scan, and expected changed mid-scan → exactly one done at +48; results reflect the originally latched expected.
- rst_n low for one edge mid-scan → all outputs zero after that edge. Separately, SETTLE_CYCLES=1 build → done at edge +32 with correct table.
